// File: rtl/sm_acc_ctrl.sv
// ============================================================================
// Module : sm_acc_ctrl (with helper sign_mag_add)
// Brief  : Tick-driven sign-magnitude accumulator with saturation, sticky
//          overflow and an accepted-operation counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sign_mag_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);
  logic [N-2:0] w_mag_a, w_mag_b, w_max, w_min, w_mag_sum;
  logic         w_sign_a, w_sign_b, w_sign_sum;

  assign w_mag_a  = i_a[N-2:0];
  assign w_mag_b  = i_b[N-2:0];
  assign w_sign_a = i_a[N-1];
  assign w_sign_b = i_b[N-1];

  always_comb begin
    if (w_mag_a > w_mag_b) begin
      w_max      = w_mag_a;
      w_min      = w_mag_b;
      w_sign_sum = w_sign_a;
    end else begin
      w_max      = w_mag_b;
      w_min      = w_mag_a;
      w_sign_sum = w_sign_b;
    end
    if (w_sign_a == w_sign_b) w_mag_sum = w_max + w_min;
    else                      w_mag_sum = w_max - w_min;
  end

  assign o_sum = {w_sign_sum, w_mag_sum};
endmodule

module sm_acc_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             add_tick,
  input  logic             sub_tick,
  input  logic [N-1:0]     din,
  output logic [N-1:0]     acc,
  output logic             ovf,
  output logic             busy,
  output logic             done_tick,
  output logic [CNT_W-1:0] op_cnt
);
  localparam logic [N-2:0] c_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_acc, r_op;
  logic             r_ovf, r_busy, r_done;
  logic [CNT_W-1:0] r_op_cnt;

  logic [N-1:0] w_core;
  logic [N-1:0] w_op_next;
  logic [N-1:0] w_res;
  logic [N-1:0] w_mag_ext;
  logic [N-2:0] w_res_mag;
  logic         w_tick, w_sub, w_same, w_sat;

  assign w_tick = add_tick | sub_tick;
  assign w_sub  = sub_tick & ~add_tick;
  // Zero-magnitude operands always carry a positive sign so no -0 enters the adder.
  assign w_op_next = {(din[N-1] ^ w_sub) & (|din[N-2:0]), din[N-2:0]};

  sign_mag_add #(.N(N)) u_core (
    .i_a   (r_acc),
    .i_b   (r_op),
    .o_sum (w_core)
  );

  // One extra bit above the magnitude exposes the carry the core drops.
  assign w_mag_ext = {1'b0, r_acc[N-2:0]} + {1'b0, r_op[N-2:0]};
  assign w_same    = (r_acc[N-1] == r_op[N-1]);
  assign w_sat     = w_same & w_mag_ext[N-1];
  assign w_res_mag = w_sat ? c_MAX : w_core[N-2:0];
  assign w_res     = {w_core[N-1] & (|w_res_mag), w_res_mag};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_op     <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_op_cnt <= '0;
    end else if (clr) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_op     <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_op_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_op     <= w_op_next;
            r_op_cnt <= r_op_cnt + CNT_W'(1);
            r_state  <= ADD;
            r_busy   <= 1'b1;
          end
        end
        ADD: begin
          r_acc   <= w_res;
          if (w_sat) r_ovf <= 1'b1;
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign acc       = r_acc;
  assign ovf       = r_ovf;
  assign busy      = r_busy;
  assign done_tick = r_done;
  assign op_cnt    = r_op_cnt;
endmodule

`default_nettype wire

// File: tb/tb_sm_acc_ctrl.sv
// ============================================================================
// Module : tb_sm_acc_ctrl
// Brief  : Directed scoreboard bench for sm_acc_ctrl (N=4, CNT_W=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sm_acc_ctrl;
  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset, clr, add_tick, sub_tick;
  logic [N-1:0]     din;
  logic [N-1:0]     acc;
  logic             ovf, busy, done_tick;
  logic [CNT_W-1:0] op_cnt;

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;

  typedef struct packed {
    logic [N-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  sm_acc_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .add_tick  (add_tick),
    .sub_tick  (sub_tick),
    .din       (din),
    .acc       (acc),
    .ovf       (ovf),
    .busy      (busy),
    .done_tick (done_tick),
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, ".acc"},  int'(acc), 0);
    chk({name, ".ovf"},  int'(ovf), 0);
    chk({name, ".busy"}, int'(busy), 0);
    chk({name, ".done"}, int'(done_tick), 0);
    chk({name, ".cnt"},  int'(op_cnt), 0);
  endtask

  // Monitor: every done_tick pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done_tick) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb.acc", int'(acc), int'(e.acc));
          chk("sb.ovf", int'(ovf), int'(e.ovf));
          chk("sb.cnt", int'(op_cnt), int'(e.cnt));
        end
      end
    end
  end

  // One accepted operation; returns at the start of cycle t+3.
  task automatic op(input logic a, input logic s, input logic [N-1:0] d,
                    input logic [N-1:0] ea, input logic eo);
    @(negedge clk);
    add_tick = a; sub_tick = s; din = d;
    model_cnt = (model_cnt + 1) % 4;
    sb.push_back('{acc: ea, ovf: eo, cnt: CNT_W'(model_cnt)});
    @(negedge clk);
    add_tick = 1'b0; sub_tick = 1'b0;
    chk("busy_t1", int'(busy), 1);
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_cnt = 0;
    chk_idle_zero("clr");
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; add_tick = 1'b0; sub_tick = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    reset = 1'b0;

    op(1, 0, 4'b0011, 4'b0011, 0);
    op(0, 1, 4'b0101, 4'b1010, 0);
    chk("cnt_after_two", int'(op_cnt), 2);

    do_clr();
    op(1, 0, 4'b0110, 4'b0110, 0);
    op(1, 0, 4'b0011, 4'b0111, 1);
    op(0, 1, 4'b0001, 4'b0110, 1);

    do_clr();
    op(1, 0, 4'b1100, 4'b1100, 0);
    op(1, 0, 4'b0100, 4'b0000, 0);
    op(0, 1, 4'b1000, 4'b0000, 0);

    // Tick held for three cycles: one operation, and op_cnt wraps 3 -> 0.
    @(negedge clk);
    add_tick = 1'b1; din = 4'b0001;
    model_cnt = (model_cnt + 1) % 4;
    sb.push_back('{acc: 4'b0001, ovf: 1'b0, cnt: CNT_W'(model_cnt)});
    @(negedge clk);
    chk("drop.busy_t1", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    add_tick = 1'b0;
    chk("drop.busy_t3", int'(busy), 0);
    chk("drop.done_t3", int'(done_tick), 0);
    chk("drop.cnt_wrap", int'(op_cnt), 0);

    op(1, 1, 4'b0010, 4'b0011, 0);
    op(1, 0, 4'b0111, 4'b0111, 1);

    // clr asserted during the ADD cycle aborts the sequence.
    @(negedge clk);
    add_tick = 1'b1; din = 4'b0010;
    @(negedge clk);
    add_tick = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_cnt = 0;
    chk_idle_zero("clr_add");
    @(negedge clk);
    chk("clr_add.no_done", int'(done_tick), 0);
    op(1, 0, 4'b0101, 4'b0101, 0);

    // Tick coinciding with clr is dropped.
    @(negedge clk);
    clr = 1'b1; add_tick = 1'b1; din = 4'b0011;
    @(negedge clk);
    clr = 1'b0; add_tick = 1'b0;
    model_cnt = 0;
    chk_idle_zero("clr_tick");

    // Async reset between edges while in DONE.
    op(1, 0, 4'b0010, 4'b0010, 0);
    @(negedge clk);
    add_tick = 1'b1; din = 4'b0001;
    @(negedge clk);
    add_tick = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_reset.done", int'(done_tick), 1);
    reset = 1'b1;
    #1;
    chk_idle_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    model_cnt = 0;
    op(1, 0, 4'b0011, 4'b0011, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
